// File: rtl/bcd9999_scan_drv_if.sv
// Bundle between the BCD counter/scan driver and its environment.
// Modports: master (controller side), slave (the driver itself).
interface bcd9999_scan_drv_if;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [2:0]  sel;
  logic [7:0]  data1;
  logic [7:0]  data10;
  logic [7:0]  data100;
  logic [7:0]  data1000;
  logic [15:0] bcd;
  logic        carry;

  modport master (
    output en, up_dn, load, load_val,
    input  sel, data1, data10, data100, data1000, bcd, carry
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output sel, data1, data10, data100, data1000, bcd, carry
  );
endinterface

// File: rtl/bcd9999_scan_drv.sv
// 4-digit BCD up/down counter with seven-segment encoders and a 0..5 scan select.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (ones digit always shown).
module bcd9999_scan_drv #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input logic               clk,
  input logic               clr_n,
  bcd9999_scan_drv_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [7:0]    SEG_ZERO  = 8'hC0;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple one BCD step; bit 16 is the wrap (9999->0000 or 0000->9999).
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        c;
    logic [3:0]  d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[i*4 +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) d = 4'd0;
          else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      r[i*4 +: 4] = d;
    end
    return {c, r};
  endfunction

  logic [TW-1:0]       presc_q, presc_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [2:0]          sel_q, sel_d;
  logic [15:0]         bcd_q, bcd_d;
  logic                carry_q, carry_d;
  logic [3:0][7:0]     seg_q, seg_d;
  logic                tick;
  logic                scan_wrap;
  logic [16:0]         step;
  logic [3:1]          blank;

  always_comb begin
    tick    = (presc_q == TICK_LAST);
    step    = bcd_step(bcd_q, bus.up_dn);
    presc_d = tick ? '0 : presc_q + TW'(1);
    bcd_d   = bcd_q;
    carry_d = 1'b0;
    // Load beats a coincident tick and restarts the prescaler phase.
    if (bus.load) begin
      bcd_d   = bcd_clamp(bus.load_val);
      presc_d = '0;
    end else if (tick && bus.en) begin
      bcd_d   = step[15:0];
      carry_d = step[16];
    end

    scan_wrap = (scan_q == SCAN_LAST);
    scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
    sel_d     = sel_q;
    if (scan_wrap) sel_d = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;

`ifdef LEADING_ZERO_BLANK_EN
    blank[3] = (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
`else
    blank = 3'b000;
`endif
    seg_d[0] = seg_enc(bcd_q[3:0]);
    for (int i = 1; i < 4; i++) begin
      seg_d[i] = blank[i] ? 8'hFF : seg_enc(bcd_q[i*4 +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      presc_q <= '0;
      scan_q  <= '0;
      sel_q   <= 3'd0;
      bcd_q   <= 16'h0000;
      carry_q <= 1'b0;
      seg_q   <= {4{SEG_ZERO}};
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.bcd      = bcd_q;
  assign bus.carry    = carry_q;
  assign bus.data1    = seg_q[0];
  assign bus.data10   = seg_q[1];
  assign bus.data100  = seg_q[2];
  assign bus.data1000 = seg_q[3];
endmodule

// File: tb/tb_bcd9999_scan_drv.sv
// Self-checking bench for bcd9999_scan_drv: directed scenarios plus randomized
// traffic compared against a decimal-arithmetic reference model.
module tb_bcd9999_scan_drv;
  localparam int TD = 4;
  localparam int SD = 3;
  localparam logic [7:0] SEGTAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  bcd9999_scan_drv_if ifc ();

  bcd9999_scan_drv #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: count held as a plain decimal integer.
  int          m_cnt   = 0;
  int          m_presc = 0;
  int          m_sdiv  = 0;
  int          m_sel   = 0;
  logic        m_carry = 1'b0;
  logic [31:0] m_data  = 32'hC0C0C0C0;

  function automatic logic [31:0] disp_of(int c);
    logic [7:0] s [4];
    s[0] = SEGTAB[c % 10];
    s[1] = SEGTAB[(c / 10) % 10];
    s[2] = SEGTAB[(c / 100) % 10];
    s[3] = SEGTAB[c / 1000];
`ifdef LEADING_ZERO_BLANK_EN
    if (c < 1000) s[3] = 8'hFF;
    if (c < 100)  s[2] = 8'hFF;
    if (c < 10)   s[1] = 8'hFF;
`endif
    return {s[3], s[2], s[1], s[0]};
  endfunction

  function automatic int clamp_val(logic [15:0] lv);
    int v = 0;
    int n;
    for (int k = 3; k >= 0; k--) begin
      n = int'((lv >> (4 * k)) & 16'hF);
      if (n > 9) n = 9;
      v = v * 10 + n;
    end
    return v;
  endfunction

  function automatic logic [15:0] exp_bcd();
    return {4'(m_cnt / 1000), 4'((m_cnt / 100) % 10), 4'((m_cnt / 10) % 10), 4'(m_cnt % 10)};
  endfunction

  function automatic logic [31:0] dut_data();
    return {ifc.data1000, ifc.data100, ifc.data10, ifc.data1};
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge.
  task automatic cyc();
    bit tk;
    @(posedge clk);
    if (!clr_n) begin
      m_cnt = 0; m_presc = 0; m_sdiv = 0; m_sel = 0;
      m_carry = 1'b0; m_data = 32'hC0C0C0C0;
    end else begin
      m_data  = disp_of(m_cnt);
      m_carry = 1'b0;
      if (ifc.load) begin
        m_cnt   = clamp_val(ifc.load_val);
        m_presc = 0;
      end else begin
        tk      = (m_presc == TD - 1);
        m_presc = (m_presc + 1) % TD;
        if (tk && ifc.en) begin
          if (ifc.up_dn) begin
            m_carry = (m_cnt == 9999);
            m_cnt   = (m_cnt + 1) % 10000;
          end else begin
            m_carry = (m_cnt == 0);
            m_cnt   = (m_cnt + 9999) % 10000;
          end
        end
      end
      if (m_sdiv == SD - 1) begin
        m_sdiv = 0;
        m_sel  = (m_sel + 1) % 6;
      end else m_sdiv++;
    end
    #1;
  endtask

  task automatic do_load(logic [15:0] v);
    ifc.load = 1'b1; ifc.load_val = v;
    cyc();
    ifc.load = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; ifc.load = 1'b1; ifc.load_val = 16'h1234;
    ifc.en = 1'b1; ifc.up_dn = 1'b1;
    repeat (3) cyc();
    n_tests++;
    if (ifc.bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd got %h want 0000", ifc.bcd); end
    n_tests++;
    if (ifc.sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", ifc.sel); end
    n_tests++;
    if (dut_data() !== 32'hC0C0C0C0) begin n_fail++; $display("FAIL reset_data got %h want C0C0C0C0", dut_data()); end
    n_tests++;
    if (ifc.carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", ifc.carry); end
    clr_n = 1'b1; ifc.load = 1'b0;
  endtask

  task automatic test_up_wrap();
    int ncarry = 0;
    ifc.en = 1'b1; ifc.up_dn = 1'b1;
    do_load(16'h9998);
    repeat (TD) cyc();
    n_tests++;
    if (ifc.bcd !== 16'h9999) begin n_fail++; $display("FAIL up_first got %h want 9999", ifc.bcd); end
    for (int i = 0; i < TD; i++) begin
      cyc();
      if (ifc.carry === 1'b1) ncarry++;
      n_tests++;
      if (ifc.bcd !== exp_bcd()) begin n_fail++; $display("FAIL up_model cyc %0d got %h want %h", i, ifc.bcd, exp_bcd()); end
    end
    n_tests++;
    if (ifc.bcd !== 16'h0000 || ifc.carry !== 1'b1) begin
      n_fail++; $display("FAIL up_wrap got bcd %h carry %b want 0000/1", ifc.bcd, ifc.carry);
    end
    n_tests++;
    if (ifc.data1 !== 8'h90) begin n_fail++; $display("FAIL up_data_lag got %h want 90", ifc.data1); end
    cyc();
    n_tests++;
    if (ifc.carry !== 1'b0 || ncarry != 1) begin
      n_fail++; $display("FAIL up_carry_pulse got carry %b count %0d want 0/1", ifc.carry, ncarry);
    end
    n_tests++;
    if (ifc.data1 !== 8'hC0) begin n_fail++; $display("FAIL up_data1 got %h want C0", ifc.data1); end
  endtask

  task automatic test_down_wrap();
    ifc.en = 1'b1; ifc.up_dn = 1'b0;
    do_load(16'h1000);
    repeat (TD) cyc();
    n_tests++;
    if (ifc.bcd !== 16'h0999) begin n_fail++; $display("FAIL down_borrow got %h want 0999", ifc.bcd); end
    do_load(16'h0000);
    repeat (TD) cyc();
    n_tests++;
    if (ifc.bcd !== 16'h9999 || ifc.carry !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap got bcd %h carry %b want 9999/1", ifc.bcd, ifc.carry);
    end
  endtask

  task automatic test_load_priority();
    int guard = 0;
    ifc.en = 1'b1; ifc.up_dn = 1'b1;
    while (m_presc != TD - 1 && guard < TD) begin cyc(); guard++; end
    do_load(16'hAB35);
    n_tests++;
    if (ifc.bcd !== 16'h9935) begin n_fail++; $display("FAIL load_clamp got %h want 9935", ifc.bcd); end
    repeat (TD - 1) cyc();
    n_tests++;
    if (ifc.bcd !== 16'h9935) begin n_fail++; $display("FAIL load_presc_restart got %h want 9935", ifc.bcd); end
    cyc();
    n_tests++;
    if (ifc.bcd !== 16'h9936) begin n_fail++; $display("FAIL load_next_step got %h want 9936", ifc.bcd); end
  endtask

  task automatic test_scan();
    int bad = 0;
    clr_n = 1'b0;
    cyc();
    clr_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (ifc.sel !== 3'((k / SD) % 6) || ifc.sel > 3'd5) begin
        bad++; $display("FAIL scan_seq k %0d got %0d want %0d", k, ifc.sel, (k / SD) % 6);
      end
      cyc();
    end
    n_tests++;
    if (bad != 0) n_fail++;
  endtask

  task automatic test_leading_digits();
    logic [31:0] want42, want0;
`ifdef LEADING_ZERO_BLANK_EN
    want42 = 32'hFFFF99A4; want0 = 32'hFFFFFFC0;
`else
    want42 = 32'hC0C099A4; want0 = 32'hC0C0C0C0;
`endif
    ifc.en = 1'b0;
    do_load(16'h0042);
    cyc();
    n_tests++;
    if (dut_data() !== want42) begin n_fail++; $display("FAIL lead_0042 got %h want %h", dut_data(), want42); end
    do_load(16'h0000);
    cyc();
    n_tests++;
    if (dut_data() !== want0) begin n_fail++; $display("FAIL lead_0000 got %h want %h", dut_data(), want0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clr_n        = ($urandom_range(0, 63) != 0);
      ifc.en       = ($urandom_range(0, 3) != 0);
      ifc.up_dn    = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 85 : 15));
      ifc.load     = ($urandom_range(0, 15) == 0);
      ifc.load_val = 16'($urandom);
      cyc();
      n_tests++;
      if (ifc.bcd !== exp_bcd() || ifc.carry !== m_carry) begin
        n_fail++; $display("FAIL rnd_count cyc %0d got %h/%b want %h/%b", i, ifc.bcd, ifc.carry, exp_bcd(), m_carry);
      end
      n_tests++;
      if (dut_data() !== m_data || ifc.sel !== 3'(m_sel)) begin
        n_fail++; $display("FAIL rnd_disp cyc %0d got %h/%0d want %h/%0d", i, dut_data(), ifc.sel, m_data, m_sel);
      end
    end
    clr_n = 1'b1; ifc.load = 1'b0;
  endtask

  initial begin
    clr_n = 1'b0; ifc.en = 1'b0; ifc.up_dn = 1'b1;
    ifc.load = 1'b0; ifc.load_val = 16'h0000;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_scan();
    test_leading_digits();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd9999_scan_drv.md
Name: bcd9999_scan_drv

Overview:
- Upstream feeder of the 4-digit LED display multiplexer.
- Keeps a 4-digit BCD counter (0000–9999), stepped up or down by a prescaled tick, with synchronous parallel load.
- Converts each digit to an active-low 8-bit seven-segment pattern.
- Generates the free-running 3-bit scan select that steps the multiplexer through its six positions.

Parameters:
- TICK_DIV, 50000000, clk cycles per count tick (≥2).
- SCAN_DIV, 50000, clk cycles per scan-select advance (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  synchronous active-low reset.
- en  input  1  count enable; sampled on tick cycles only.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  16  BCD load value {thousands, hundreds, tens, ones}.
- sel  output  3  scan select to display mux.
- data1  output  8  ones-digit segment pattern.
- data10  output  8  tens-digit segment pattern.
- data100  output  8  hundreds-digit segment pattern.
- data1000  output  8  thousands-digit segment pattern.
- bcd  output  16  current count, BCD.
- carry  output  1  one-cycle pulse on wrap.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: clr_n sampled low at a rising clk edge resets the block.
- Reset values: bcd = 0x0000; prescaler = 0; scan divider = 0; sel = 3'b000; carry = 0; data1..data1000 = 8'b1100_0000 (digit "0").
- Segment encoding: active-low; bit7 = dp (always 1), bits6..0 = g,f,e,d,c,b,a.
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - Any non-BCD value encodes as FF (blank).
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is asserted internally for the single cycle in which the prescaler equals TICK_DIV-1.
- Counter update, evaluated at each rising edge, in priority order:
  1. load = 1: bcd ← load_val, with each nibble > 9 clamped to 9. Prescaler cleared to 0. carry = 0.
  2. tick & en & up_dn: BCD increment with ripple per digit (9→0 carries into the next digit). 9999→0000 with carry = 1 for one cycle.
  3. tick & en & ~up_dn: BCD decrement with borrow (0→9). 0000→9999 with carry = 1 for one cycle.
  4. Otherwise: hold, carry = 0.
- load and tick in the same cycle: load wins and the tick is lost.
- en low on a tick cycle: no step; the prescaler still wraps.
- Segment outputs are registered.
  - data* reflect bcd with 1-cycle latency: a bcd change at edge N appears on data* at edge N+1.
  - bcd itself updates at edge N.
- Scan select:
  - Divider counts 0..SCAN_DIV-1.
  - On wrap, sel advances 0→1→2→3→4→5→0.
  - Values 6 and 7 are never produced.
  - sel is independent of load, en and the counter.
- Reset asserted mid-operation: all state returns to reset values on that edge. No partial update, no carry pulse.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits encode as FF (blank), so e.g. 0042 shows "  42".
  - Thousands digit is blanked if 0.
  - Hundreds digit is blanked if it and thousands are both 0.
  - Tens digit is blanked if it, hundreds and thousands are all 0.
  - Ones digit is never blanked, so 0000 shows "0".
  - Blanking follows the same 1-cycle register latency as the segment patterns.
- Undefined: all four digits are always encoded, leading zeros included. Reset values are unchanged.

Test Plan:
- Reset: hold clr_n = 0 for 3 cycles with load = 1 and load_val = 0x1234 → after the edge, bcd = 0000, sel = 0, data* = C0, carry = 0.
- Up wrap: TICK_DIV = 4, load 0x9998, en = 1, up_dn = 1 → after tick 1, bcd = 9999. After tick 2, bcd = 0000 and carry pulses exactly 1 cycle. data1 = C0 one cycle after bcd.
- Down wrap/borrow:
  - load 0x1000, up_dn = 0, one tick → bcd = 0999.
  - load 0x0000, one tick → bcd = 9999 with carry = 1.
- Load priority and clamp: assert load = 1 with load_val = 0xAB35 on a tick cycle → bcd = 0x9935, no step taken, prescaler restarts from 0.
- Scan: SCAN_DIV = 3, run 24 cycles → sel sequence 0,1,2,3,4,5,0,1 with each value held exactly 3 cycles; never 6 or 7.
- LEADING_ZERO_BLANK_EN defined, load 0x0042 → data1000 = FF, data100 = FF, data10 = 99, data1 = A4. Load 0x0000 → data1 = C0, other three = FF.
